rpll_ctrl: RTL

- Supervisory controller sitting directly around rpll_sm.
- Drives the PLL sequencer's enable and a soft-reset request, and consumes its ready, loss_of_lock and ret_exit_timeout outputs.
- Gates the PLL output clock to downstream logic only after lock has been stable for a programmable time; performs bounded automatic relock on failure; raises maskable W1C interrupts.
- All inputs are synchronous to clk; sequencer outputs are registered in the same domain, so no synchronizers are needed.

---
 rtl/rpll_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/rpll_ctrl.sv
// rtl/rpll_ctrl.sv - supervisory controller around rpll_sm: clock release, bounded relock, interrupts
module rpll_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             swi_enable,
  input  logic             swi_auto_relock,
  input  logic [3:0]       swi_max_retries,
  input  logic [CNT_W-1:0] swi_lock_timeout,
  input  logic [7:0]       swi_ready_stable_count,
  input  logic [7:0]       swi_relock_off_time,
  input  logic [3:0]       swi_int_en,
  input  logic [3:0]       int_clear,
  input  logic             sm_ready,
  input  logic             sm_loss_of_lock,
  input  logic             sm_ret_exit_timeout,
  output logic             sm_enable,
  output logic             sm_reset_req,
  output logic             clk_out_en,
  output logic [3:0]       int_status,
  output logic             irq,
  output logic [3:0]       retry_count,
  output logic             relock_failed,
  output logic [2:0]       ctrl_state
);

  typedef enum logic [2:0] {
    ST_OFF         = 3'd0,
    ST_WAIT_READY  = 3'd1,
    ST_STABLE_WAIT = 3'd2,
    ST_RUNNING     = 3'd3,
    ST_RELOCK_OFF  = 3'd4,
    ST_FAILED      = 3'd5
  } state_t;

  // Interrupt bit positions inside int_status.
  localparam int INT_LOCK     = 0;
  localparam int INT_LOL      = 1;
  localparam int INT_RET_TO   = 2;
  localparam int INT_LOCK_TO  = 3;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sm_enable_q, sm_enable_d;
  logic             sm_reset_req_q, sm_reset_req_d;
  logic             clk_out_en_q, clk_out_en_d;
  logic [3:0]       int_status_q, int_status_d;
  logic             irq_q, irq_d;
  logic [3:0]       retry_count_q, retry_count_d;
  logic             relock_failed_q, relock_failed_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] stable_target;
  logic [CNT_W-1:0] relock_target;
  logic [7:0]       relock_off_eff;
  logic [3:0]       retry_inc;
  logic             timeout_hit;
  logic             fail;
  logic [3:0]       int_set;

  // Saturating helpers and compare targets shared by the FSM.
  always_comb begin
    cnt_inc        = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    retry_inc      = (retry_count_q == 4'hF) ? 4'hF : retry_count_q + 4'd1;
    relock_off_eff = (swi_relock_off_time < 8'd3) ? 8'd3 : swi_relock_off_time;
    stable_target  = CNT_W'(swi_ready_stable_count);
    relock_target  = CNT_W'(relock_off_eff);
    timeout_hit    = (swi_lock_timeout != '0) && (cnt_q == swi_lock_timeout);
  end

  // Next-state, counter, output and interrupt-set computation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    sm_enable_d     = sm_enable_q;
    sm_reset_req_d  = sm_reset_req_q;
    clk_out_en_d    = clk_out_en_q;
    retry_count_d   = retry_count_q;
    relock_failed_d = relock_failed_q;
    fail            = 1'b0;
    int_set         = 4'b0000;

    if (!swi_enable) begin
      // Software disable overrides everything; retry history is kept.
      state_d        = ST_OFF;
      clk_out_en_d   = 1'b0;
      sm_enable_d    = 1'b0;
      sm_reset_req_d = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d         = ST_WAIT_READY;
          sm_enable_d     = 1'b1;
          sm_reset_req_d  = 1'b0;
          clk_out_en_d    = 1'b0;
          cnt_d           = '0;
          retry_count_d   = 4'd0;
          relock_failed_d = 1'b0;
        end

        ST_WAIT_READY: begin
          if (sm_ready) begin
            state_d = ST_STABLE_WAIT;
            cnt_d   = '0;
          end else if (sm_ret_exit_timeout) begin
            int_set[INT_RET_TO] = 1'b1;
            fail                = 1'b1;
          end else if (timeout_hit) begin
            int_set[INT_LOCK_TO] = 1'b1;
            fail                 = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_STABLE_WAIT: begin
          if (!sm_ready) begin
            // A ready dropout restarts acquisition without costing a retry.
            state_d = ST_WAIT_READY;
            cnt_d   = '0;
          end else if (cnt_q == stable_target) begin
            state_d           = ST_RUNNING;
            clk_out_en_d      = 1'b1;
            int_set[INT_LOCK] = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_RUNNING: begin
          if (sm_loss_of_lock) begin
            clk_out_en_d        = 1'b0;
            int_set[INT_LOL]    = 1'b1;
            int_set[INT_RET_TO] = sm_ret_exit_timeout;
            fail                = 1'b1;
          end else if (!sm_ready) begin
            // Retention entry: gate the clock and wait for ready to return.
            clk_out_en_d = 1'b0;
            state_d      = ST_WAIT_READY;
            cnt_d        = '0;
          end
        end

        ST_RELOCK_OFF: begin
          sm_enable_d    = 1'b0;
          sm_reset_req_d = 1'b1;
          if (cnt_q == relock_target) begin
            state_d        = ST_WAIT_READY;
            sm_enable_d    = 1'b1;
            sm_reset_req_d = 1'b0;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_FAILED: begin
          sm_enable_d     = 1'b0;
          sm_reset_req_d  = 1'b1;
          clk_out_en_d    = 1'b0;
          relock_failed_d = 1'b1;
        end

        default: begin
          state_d        = ST_OFF;
          sm_enable_d    = 1'b0;
          sm_reset_req_d = 1'b1;
          clk_out_en_d   = 1'b0;
          cnt_d          = '0;
        end
      endcase

      // Any failure either schedules a bounded relock or parks in FAILED.
      if (fail) begin
        clk_out_en_d   = 1'b0;
        sm_enable_d    = 1'b0;
        sm_reset_req_d = 1'b1;
        cnt_d          = '0;
        if (swi_auto_relock && (retry_count_q < swi_max_retries)) begin
          state_d       = ST_RELOCK_OFF;
          retry_count_d = retry_inc;
        end else begin
          state_d         = ST_FAILED;
          relock_failed_d = 1'b1;
        end
      end
    end
  end

  // Sticky W1C interrupt status (set beats clear) and the registered irq.
  always_comb begin
    int_status_d = (int_status_q & ~int_clear) | int_set;
    irq_d        = |(int_status_q & swi_int_en);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_OFF;
      cnt_q           <= '0;
      sm_enable_q     <= 1'b0;
      sm_reset_req_q  <= 1'b1;
      clk_out_en_q    <= 1'b0;
      int_status_q    <= 4'b0000;
      irq_q           <= 1'b0;
      retry_count_q   <= 4'd0;
      relock_failed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sm_enable_q     <= sm_enable_d;
      sm_reset_req_q  <= sm_reset_req_d;
      clk_out_en_q    <= clk_out_en_d;
      int_status_q    <= int_status_d;
      irq_q           <= irq_d;
      retry_count_q   <= retry_count_d;
      relock_failed_q <= relock_failed_d;
    end
  end

  assign sm_enable     = sm_enable_q;
  assign sm_reset_req  = sm_reset_req_q;
  assign clk_out_en    = clk_out_en_q;
  assign int_status    = int_status_q;
  assign irq           = irq_q;
  assign retry_count   = retry_count_q;
  assign relock_failed = relock_failed_q;
  assign ctrl_state    = state_q;

endmodule
